// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, operand/result
// select encodings, and the control bundle carried into ID/EX.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_RD1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } alu_src_a_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        alu_src;
    alu_src_a_e  alu_src_a;
    alu_ctl_e    alu_ctl;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops; it always picks SRA vs SRL.
  function automatic alu_ctl_e alu_decode(input logic [2:0] funct3,
                                          input logic       funct7_5,
                                          input logic       is_rtype);
    alu_ctl_e op;
    case (funct3)
      3'b000:  op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: two async read ports, one write port,
// x0 hardwired to zero and a write-through bypass from the writeback port.
module reg_file
  import riscv_pkg::*;
#(
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_valid;

  assign wr_valid = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (wr_valid && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (wr_valid && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control/immediate decode, register-file read, and the
// ID/EX pipeline register with flush-to-bubble and synchronous reset.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            JalrE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ALUSrcAE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic            IllegalE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  logic [4:0]      rd_d;
  ctrl_t           ctrl_d, ctrl_q;
  imm_type_e       imm_sel;
  logic            illegal_d, no_rd;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd_idx = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  reg_file #(.NREGS(NREGS)) u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  always_comb begin
    ctrl_d    = '0;
    imm_sel   = IMM_NONE;
    illegal_d = 1'b0;
    no_rd     = 1'b0;
    if (InstrD[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_ctl   = alu_decode(funct3, InstrD[30], 1'b1);
        end
        OPC_OP_IMM: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_ctl   = alu_decode(funct3, InstrD[30], 1'b0);
          imm_sel          = IMM_I;
        end
        OPC_LOAD: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.result_src = RES_MEM;
          ctrl_d.alu_src    = 1'b1;
          imm_sel           = IMM_I;
        end
        OPC_STORE: begin
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          imm_sel          = IMM_S;
          no_rd            = 1'b1;
        end
        OPC_BRANCH: begin
          ctrl_d.branch  = 1'b1;
          ctrl_d.alu_ctl = ALU_SUB;
          imm_sel        = IMM_B;
          no_rd          = 1'b1;
        end
        OPC_JAL: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.result_src = RES_PC4;
          imm_sel           = IMM_J;
        end
        OPC_JALR: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.jalr       = 1'b1;
          ctrl_d.result_src = RES_PC4;
          ctrl_d.alu_src    = 1'b1;
          imm_sel           = IMM_I;
        end
        OPC_LUI: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_src_a = SRCA_ZERO;
          imm_sel          = IMM_U;
        end
        OPC_AUIPC: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_src_a = SRCA_PC;
          imm_sel          = IMM_U;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  assign rd_d = no_rd ? 5'd0 : rd_idx;

  always_comb begin
    imm_d = '0;
    case (imm_sel)
      IMM_I:   imm_d = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_d = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_U:   imm_d = {InstrD[31:12], 12'b0};
      IMM_J:   imm_d = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      IllegalE <= 1'b0;
      RdE      <= '0;
      Funct3E  <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      IllegalE <= illegal_d;
      RdE      <= rd_d;
      Funct3E  <= funct3;
      RD1E     <= rd1_d;
      RD2E     <= rd2_d;
      ImmExtE  <= imm_d;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      // Bubble: kill every side effect but let the operand datapath load.
      if (FlushE) begin
        ctrl_q.reg_write  <= 1'b0;
        ctrl_q.result_src <= RES_ALU;
        ctrl_q.mem_write  <= 1'b0;
        ctrl_q.jump       <= 1'b0;
        ctrl_q.jalr       <= 1'b0;
        ctrl_q.branch     <= 1'b0;
        IllegalE          <= 1'b0;
        RdE               <= '0;
      end
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign JalrE       = ctrl_q.jalr;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUSrcAE    = ctrl_q.alu_src_a;
  assign ALUControlE = ctrl_q.alu_ctl;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: a decode vector table plus hand-written
// sequences for reset, register-file bypass, x0 and flush behaviour.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE, ALUSrcAE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .IllegalE(IllegalE)
  );

  logic [192:0] all_e;
  assign all_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE,
                  ALUSrcAE, ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
                  RdE, Rs1E, Rs2E, IllegalE};

  logic [14:0] act_ctrl;
  assign act_ctrl = {RegWriteE, ResultSrcE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE,
                     ALUSrcAE, ALUControlE, IllegalE};

  typedef struct {
    logic [31:0] instr;
    logic        rw;
    logic [1:0]  rs;
    logic        mw, j, jr, br, as;
    logic [1:0]  asa;
    logic [3:0]  alu;
    logic        ill;
    logic        imm_ok;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    checks++;
    if (all_e !== '0) begin
      errors++;
      $display("FAIL %s: E outputs 0x%0h expected all zero", name, all_e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                instr          rw    rs     mw    j     jr    br    as    asa    alu      ill   immok imm            rd
    vecs[0]  = '{32'h00500093, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h00000005, 5'd1};
    vecs[1]  = '{32'h0040A183, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h00000004, 5'd3};
    vecs[2]  = '{32'h0020A423, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h00000008, 5'd0};
    vecs[3]  = '{32'hFE208CE3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b1, 32'hFFFFFFF8, 5'd0};
    vecs[4]  = '{32'h402083B3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, 32'h00000000, 5'd7};
    vecs[5]  = '{32'h4020D3B3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1001, 1'b0, 1'b0, 32'h00000000, 5'd7};
    vecs[6]  = '{32'h4030D413, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b1001, 1'b0, 1'b1, 32'h00000403, 5'd8};
    vecs[7]  = '{32'h40008493, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h00000400, 5'd9};
    vecs[8]  = '{32'hFFF0F513, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd10};
    vecs[9]  = '{32'h0020A6B3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0101, 1'b0, 1'b0, 32'h00000000, 5'd13};
    vecs[10] = '{32'h00F0C713, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0100, 1'b0, 1'b1, 32'h0000000F, 5'd14};
    vecs[11] = '{32'h0020D7B3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 32'h00000000, 5'd15};
    vecs[12] = '{32'h123455B7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 32'h12345000, 5'd11};
    vecs[13] = '{32'hFFFFF617, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 32'hFFFFF000, 5'd12};
    vecs[14] = '{32'hFFDFF0EF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd1};
    vecs[15] = '{32'h00C280E7, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h0000000C, 5'd1};
    vecs[16] = '{32'h00000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h00000000, 5'd0};
    vecs[17] = '{32'h00000010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h00000000, 5'd0};
    vecs[18] = '{32'h0000007F, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h00000000, 5'd0};
    vecs[19] = '{32'h00000013, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 32'h00000000, 5'd0};

    rst = 1'b1; InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
    FlushE = 1'b0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;

    tick(); chk_all_zero("reset_cycle1");
    tick(); chk_all_zero("reset_cycle2");

    rst = 1'b0; InstrD = 32'h00028333;            // add x6,x5,x0
    tick();
    chk("x5_before_write", 64'(RD1E), 64'h0);
    chk("add_rd", 64'(RdE), 64'd6);

    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h12345678; InstrD = 32'h00000013;
    tick();
    RegWriteW = 1'b0; InstrD = 32'h00028333;
    tick();
    chk("x5_readback", 64'(RD1E), 64'h12345678);

    InstrD = 32'h00500093;
    tick();
    chk("addi_rd1_x0", 64'(RD1E), 64'h0);

    for (int i = 0; i < NV; i++) begin
      logic [31:0] ins;
      logic [14:0] exp_ctrl;
      ins = vecs[i].instr;
      exp_ctrl = {vecs[i].rw, vecs[i].rs, vecs[i].mw, vecs[i].j, vecs[i].jr, vecs[i].br,
                  vecs[i].as, vecs[i].asa, vecs[i].alu, vecs[i].ill};
      InstrD = ins; PCD = 32'h100 + 32'(i) * 4; PCPlus4D = PCD + 32'd4;
      #1;
      chk($sformatf("rs_d[%0d]", i), 64'({Rs1D, Rs2D}), 64'({ins[19:15], ins[24:20]}));
      tick();
      chk($sformatf("ctrl[%0d]", i), 64'(act_ctrl), 64'(exp_ctrl));
      if (vecs[i].imm_ok) chk($sformatf("imm[%0d]", i), 64'(ImmExtE), 64'(vecs[i].imm));
      chk($sformatf("rd[%0d]", i), 64'(RdE), 64'(vecs[i].rd));
      chk($sformatf("rs_f3_e[%0d]", i), 64'({Rs1E, Rs2E, Funct3E}),
          64'({ins[19:15], ins[24:20], ins[14:12]}));
      chk($sformatf("pc_e[%0d]", i), {PCE, PCPlus4E}, {32'h100 + 32'(i) * 4, 32'h104 + 32'(i) * 4});
    end

    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF; InstrD = 32'h00318233;
    tick();
    chk("bypass_rd1", 64'(RD1E), 64'hDEADBEEF);
    chk("bypass_rd2", 64'(RD2E), 64'hDEADBEEF);
    chk("bypass_rd", 64'(RdE), 64'd4);
    RegWriteW = 1'b0;
    tick();
    chk("x3_stored", 64'(RD1E), 64'hDEADBEEF);

    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF; InstrD = 32'h00000233;
    tick();
    chk("x0_no_bypass", 64'({RD1E, RD2E}), 64'h0);
    RegWriteW = 1'b0;
    tick();
    chk("x0_after_write", 64'(RD1E), 64'h0);

    FlushE = 1'b1; RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hA5A5A5A5; InstrD = 32'h00500093;
    tick();
    chk("flush_addi", 64'({RegWriteE, MemWriteE, JumpE, JalrE, BranchE, IllegalE, ResultSrcE, RdE}), 64'h0);
    RegWriteW = 1'b0; InstrD = 32'hFFDFF0EF;
    tick();
    chk("flush_jal", 64'({RegWriteE, MemWriteE, JumpE, JalrE, BranchE, IllegalE, ResultSrcE, RdE}), 64'h0);
    InstrD = 32'h0000007F;
    tick();
    chk("flush_illegal", 64'(IllegalE), 64'h0);
    FlushE = 1'b0; InstrD = 32'h00038233;         // add x4,x7,x0
    tick();
    chk("flush_wb_kept", 64'(RD1E), 64'hA5A5A5A5);
    chk("unflushed_ctrl", 64'({RegWriteE, RdE}), 64'({1'b1, 5'd4}));

    rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h11111111; FlushE = 1'b1;
    InstrD = 32'h00318233;
    tick();
    chk_all_zero("reset_midop");
    rst = 1'b0; RegWriteW = 1'b0; FlushE = 1'b0; InstrD = 32'h00918233;   // add x4,x3,x9
    tick();
    chk("reset_clears_x3", 64'(RD1E), 64'h0);
    chk("reset_beats_wb_x9", 64'(RD2E), 64'h0);
    InstrD = 32'h00028333;
    tick();
    chk("reset_clears_x5", 64'(RD1E), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
